mem_burst_master: RTL and testbench
===================================

// Module: mem_burst_master
// PURPOSE
//  Initiator for the 32x16 single-port async-write memory (we/address/data_in/data_out).
//  Accepts burst commands over valid/ready, streams write data into memory or read data out,
//  and sequences mem_we so address/data never change while the strobe is high.
//  Sits between the datapath and the memory.
// PARAMETERS
//  AW  5   address width; memory depth = 2**AW
//  DW  16  data width
// PORTS
//  clk           in   1   system clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  cmd_valid     in   1   command offered
//  cmd_ready     out  1   command accepted when valid&ready
//  cmd_write     in   1   1=write burst, 0=read burst
//  cmd_addr      in   AW  burst start address
//  cmd_len       in   AW  beats-1 (0..2**AW-1)
//  wr_data       in   DW  write beat data
//  wr_valid      in   1   write beat offered
//  wr_ready      out  1   write beat accepted when valid&ready
//  rd_data       out  DW  read beat data (registered)
//  rd_valid      out  1   read beat available
//  rd_ready      in   1   read beat consumed when valid&ready
//  busy          out  1   high in every state except IDLE
//  done          out  1   one-cycle pulse at burst completion
//  mem_we        out  1   to memory we
//  mem_address   out  AW  to memory address
//  mem_wdata     out  DW  to memory data_in
//  mem_rdata     in   DW  from memory data_out (Z while mem_we=1; never sampled then)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE; async assert drops mem_we immediately.
//  All outputs registered.
//  States: IDLE, W_WAIT, W_SETUP, W_STROBE, R_SETUP, R_VALID, DONE.
//  IDLE: cmd_ready=1. On cmd accept:
//   - latch addr; beat counter = cmd_len
//   - go to W_WAIT if cmd_write, else R_SETUP
//  W_WAIT: wr_ready=1, mem_we=0. On wr_valid:
//   - register wr_data -> mem_wdata, current addr -> mem_address
//   - go to W_SETUP
//  W_SETUP: mem_we=0, address/data stable. Next: W_STROBE.
//  W_STROBE: mem_we=1 for exactly one cycle; mem_address/mem_wdata unchanged.
//   Next: DONE if counter==0, else counter--, addr++ and W_WAIT.
//  Write beat: min 3 cycles (accept, setup, strobe). mem_we is never high in two consecutive cycles.
//  R_SETUP: mem_we=0, mem_address=addr; at end of cycle capture mem_rdata -> rd_data, rd_valid=1.
//   Next: R_VALID.
//  R_VALID: rd_valid held, rd_data stable until rd_ready.
//   On handshake: rd_valid=0; DONE if counter==0, else counter--, addr++ and R_SETUP.
//  Read latency: cmd accept at edge N -> rd_valid at edge N+2.
//  DONE: done=1 for one cycle, busy=1, mem_we=0. Next: IDLE.
//  Address wraps modulo 2**AW (31 -> 0 at AW=5).
//  cmd_len = 2**AW-1 covers the whole array.
//  cmd_valid outside IDLE is ignored (cmd_ready=0).
//  wr_ready=0 outside W_WAIT; rd_valid=0 outside R_VALID.
//  Reset mid-burst: burst abandoned, not resumed. Beats already strobed stay written; no further strobe.
// CONFIGURATION
//  MEM_BURST_MASTER_CHECKSUM_EN defined:
//   - extra output checksum [DW] = XOR of all beats of the current burst (written or read)
//   - cleared to 0 on cmd accept; final value stable from the done pulse until the next accept
//   - reset value 0
//  Undefined: port and logic absent; all other behaviour identical.
// TESTING
//  1. Write addr=3 len=0 data=16'hA5A5, then read addr=3 len=0:
//     exactly one mem_we pulse at address 3; rd_data=16'hA5A5 two cycles after read accept.
//  2. Write addr=30 len=3 data 1,2,3,4, then read back:
//     addresses 30,31,0,1; data 1,2,3,4; done pulses once per burst.
//  3. Read len=2 with rd_ready low for 5 cycles per beat:
//     rd_data/rd_valid held stable; no address advance until handshake.
//  4. wr_valid gaps of 0..4 cycles:
//     mem_we never high while mem_address or mem_wdata changes; never two consecutive cycles.
//  5. rst_n low during W_SETUP of beat 2 of 4:
//     mem_we=0 immediately; only beat 1 present in memory; IDLE with cmd_ready=1 after release.
//  6. With MEM_BURST_MASTER_CHECKSUM_EN, write 16'h00FF, 16'h0F0F:
//     checksum=16'h0FF0 at done.

Source files
------------

// File: rtl/mem_burst_master_if.sv
// Bundled command, beat-stream, status and memory-side signals for mem_burst_master.
// The checksum signal exists only when MEM_BURST_MASTER_CHECKSUM_EN is defined.
interface mem_burst_master_if #(
    parameter int AW = 5,
    parameter int DW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          busy;
    logic          done;
    logic          mem_we;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef MEM_BURST_MASTER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    modport master (
`ifdef MEM_BURST_MASTER_CHECKSUM_EN
        output checksum,
`endif
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_data, wr_valid, rd_ready, mem_rdata,
        output cmd_ready, wr_ready, rd_data, rd_valid,
        output busy, done, mem_we, mem_address, mem_wdata
    );

    modport slave (
`ifdef MEM_BURST_MASTER_CHECKSUM_EN
        input  checksum,
`endif
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_data, wr_valid, rd_ready, mem_rdata,
        input  cmd_ready, wr_ready, rd_data, rd_valid,
        input  busy, done, mem_we, mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port async-write memory; every output is registered.
// Optional burst XOR checksum output enabled by defining MEM_BURST_MASTER_CHECKSUM_EN.
module mem_burst_master #(
    parameter int AW = 5,
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_burst_master_if.master   bus
);
    typedef enum logic [2:0] {
        IDLE, W_WAIT, W_SETUP, W_STROBE, R_SETUP, R_VALID, DONE
    } state_t;

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] cnt_q;
    logic          settle_q;
    logic          cmd_ready_q;
    logic          wr_ready_q;
    logic          rd_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_address_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rd_data_q;
`ifdef MEM_BURST_MASTER_CHECKSUM_EN
    logic [DW-1:0] checksum_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            settle_q      <= 1'b0;
            cmd_ready_q   <= 1'b0;
            wr_ready_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            rd_data_q     <= '0;
`ifdef MEM_BURST_MASTER_CHECKSUM_EN
            checksum_q    <= '0;
`endif
        end else begin
            done_q   <= 1'b0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        addr_q      <= bus.cmd_addr;
                        cnt_q       <= bus.cmd_len;
                        settle_q    <= 1'b0;
`ifdef MEM_BURST_MASTER_CHECKSUM_EN
                        checksum_q  <= '0;
`endif
                        if (bus.cmd_write) begin
                            wr_ready_q <= 1'b1;
                            state_q    <= W_WAIT;
                        end else begin
                            mem_address_q <= bus.cmd_addr;
                            state_q       <= R_SETUP;
                        end
                    end
                end
                W_WAIT: begin
                    // Address and data are loaded together, one full cycle before the strobe.
                    if (bus.wr_valid && wr_ready_q) begin
                        wr_ready_q    <= 1'b0;
                        mem_wdata_q   <= bus.wr_data;
                        mem_address_q <= addr_q;
`ifdef MEM_BURST_MASTER_CHECKSUM_EN
                        checksum_q    <= checksum_q ^ bus.wr_data;
`endif
                        state_q       <= W_SETUP;
                    end
                end
                W_SETUP: begin
                    mem_we_q <= 1'b1;
                    state_q  <= W_STROBE;
                end
                W_STROBE: begin
                    if (cnt_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q      <= cnt_q - 1'b1;
                        addr_q     <= addr_q + 1'b1;
                        wr_ready_q <= 1'b1;
                        state_q    <= W_WAIT;
                    end
                end
                R_SETUP: begin
                    // Address gets one settle cycle before the async read port is sampled.
                    if (!settle_q) begin
                        settle_q <= 1'b1;
                    end else begin
                        settle_q   <= 1'b0;
                        rd_data_q  <= bus.mem_rdata;
                        rd_valid_q <= 1'b1;
`ifdef MEM_BURST_MASTER_CHECKSUM_EN
                        checksum_q <= checksum_q ^ bus.mem_rdata;
`endif
                        state_q    <= R_VALID;
                    end
                end
                R_VALID: begin
                    if (bus.rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (cnt_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cnt_q         <= cnt_q - 1'b1;
                            addr_q        <= addr_q + 1'b1;
                            mem_address_q <= addr_q + 1'b1;
                            state_q       <= R_SETUP;
                        end
                    end
                end
                DONE: begin
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.wr_ready    = wr_ready_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
`ifdef MEM_BURST_MASTER_CHECKSUM_EN
    assign bus.checksum    = checksum_q;
`endif
endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a 32x16 async-write memory model and strobe monitor.
module tb_mem_burst_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    mem_burst_master_if #(.AW(5), .DW(16)) bus();
    mem_burst_master #(.AW(5), .DW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Memory model and write-strobe protocol monitor, sampled mid-cycle.
    logic [15:0] mem_arr [32];
    logic [4:0]  strobe_q [$];
    int          viol = 0;
    int          done_cnt = 0;
    logic        prev_we = 1'b0;
    logic [4:0]  prev_addr = '0;
    logic [15:0] prev_data = '0;

    assign bus.mem_rdata = bus.mem_we ? 16'hxxxx : mem_arr[bus.mem_address];

    always @(negedge clk) begin
        if (bus.mem_we) begin
            mem_arr[bus.mem_address] <= bus.mem_wdata;
            strobe_q.push_back(bus.mem_address);
        end
        if ((bus.mem_we && prev_we) ||
            ((bus.mem_we || prev_we) && (bus.mem_address !== prev_addr || bus.mem_wdata !== prev_data)))
            viol <= viol + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
        prev_we   <= bus.mem_we;
        prev_addr <= bus.mem_address;
        prev_data <= bus.mem_wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [4:0] a, input logic [4:0] l);
        int n = 0;
        bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_len = l; bus.cmd_valid = 1'b1;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) begin total++; bad++; $display("FAIL cmd_timeout: cmd_ready never rose"); end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic write_beat(input logic [15:0] d, input int gap);
        int n = 0;
        repeat (gap) tick();
        bus.wr_data = d; bus.wr_valid = 1'b1;
        while (bus.wr_ready !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) begin total++; bad++; $display("FAIL wr_timeout: wr_ready never rose"); end
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_rd();
        int n = 0;
        while (bus.rd_valid !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) begin total++; bad++; $display("FAIL rd_timeout: rd_valid never rose"); end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin tick(); n++; end
        if (n >= 200) begin total++; bad++; $display("FAIL idle_timeout: busy stuck high"); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL rst_ctrl: ready/busy/done/we=%b%b%b%b want 0000", bus.cmd_ready, bus.busy, bus.done, bus.mem_we); end
        total++; if (bus.wr_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.mem_address !== 5'd0 || bus.mem_wdata !== 16'h0 || bus.rd_data !== 16'h0) begin
            bad++; $display("FAIL rst_data: wr_ready=%b rd_valid=%b addr=%h wdata=%h rdata=%h want all 0",
                            bus.wr_ready, bus.rd_valid, bus.mem_address, bus.mem_wdata, bus.rd_data); end
        rst_n = 1'b1;
        tick();
        total++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rst_release: cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy); end
    endtask

    task automatic test_single();
        int d0 = done_cnt;
        strobe_q.delete();
        send_cmd(1'b1, 5'd3, 5'd0);
        total++; if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            bad++; $display("FAIL w_wait: wr_ready=%b busy=%b cmd_ready=%b want 1 1 0", bus.wr_ready, bus.busy, bus.cmd_ready); end
        bus.wr_data = 16'hA5A5; bus.wr_valid = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        total++; if (bus.mem_address !== 5'd3 || bus.mem_wdata !== 16'hA5A5 || bus.mem_we !== 1'b0 || bus.wr_ready !== 1'b0) begin
            bad++; $display("FAIL w_setup: addr=%h data=%h we=%b wr_ready=%b want 03 a5a5 0 0",
                            bus.mem_address, bus.mem_wdata, bus.mem_we, bus.wr_ready); end
        tick();
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL w_strobe: we=%b want 1", bus.mem_we); end
        tick();
        total++; if (bus.mem_we !== 1'b0 || bus.done !== 1'b1 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL w_done: we=%b done=%b busy=%b want 0 1 1", bus.mem_we, bus.done, bus.busy); end
        tick();
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL w_idle: done=%b busy=%b cmd_ready=%b want 0 0 1", bus.done, bus.busy, bus.cmd_ready); end
        total++; if (strobe_q.size() != 1 || mem_arr[3] !== 16'hA5A5) begin
            bad++; $display("FAIL w_mem: strobes=%0d mem[3]=%h want 1 a5a5", strobe_q.size(), mem_arr[3]); end
        send_cmd(1'b0, 5'd3, 5'd0);
        total++; if (bus.rd_valid !== 1'b0 || bus.mem_address !== 5'd3 || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL r_setup: rd_valid=%b addr=%h we=%b want 0 03 0", bus.rd_valid, bus.mem_address, bus.mem_we); end
        tick();
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL r_early: rd_valid=%b want 0", bus.rd_valid); end
        tick();
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hA5A5) begin
            bad++; $display("FAIL r_latency: rd_valid=%b rd_data=%h want 1 a5a5", bus.rd_valid, bus.rd_data); end
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        total++; if (bus.rd_valid !== 1'b0 || bus.done !== 1'b1) begin
            bad++; $display("FAIL r_done: rd_valid=%b done=%b want 0 1", bus.rd_valid, bus.done); end
        wait_idle();
        tick();
        total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL single_done_cnt: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_wrap();
        logic [4:0]  ea [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
        logic [15:0] ed [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
        int d0 = done_cnt;
        strobe_q.delete();
        send_cmd(1'b1, 5'd30, 5'd3);
        for (int i = 0; i < 4; i++) write_beat(ed[i], 0);
        wait_idle();
        tick();
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL wrap_wr_done: got %0d want 1", done_cnt - d0); end
        total++; if (strobe_q.size() != 4) begin bad++; $display("FAIL wrap_strobes: got %0d want 4", strobe_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            total++; if (strobe_q[i] !== ea[i] || mem_arr[ea[i]] !== ed[i]) begin
                bad++; $display("FAIL wrap_wr%0d: addr=%0d data=%h want %0d %h", i, strobe_q[i], mem_arr[ea[i]], ea[i], ed[i]); end
        end
        d0 = done_cnt;
        send_cmd(1'b0, 5'd30, 5'd3);
        for (int i = 0; i < 4; i++) begin
            wait_rd();
            total++; if (bus.rd_data !== ed[i] || bus.mem_address !== ea[i]) begin
                bad++; $display("FAIL wrap_rd%0d: data=%h addr=%0d want %h %0d", i, bus.rd_data, bus.mem_address, ed[i], ea[i]); end
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
        end
        wait_idle();
        tick();
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL wrap_rd_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_rd_backpressure();
        logic [15:0] ed [3] = '{16'd1, 16'd2, 16'd3};
        logic [4:0]  ea [3] = '{5'd30, 5'd31, 5'd0};
        logic [15:0] d;
        logic [4:0]  a;
        bit          stable;
        send_cmd(1'b0, 5'd30, 5'd2);
        for (int i = 0; i < 3; i++) begin
            wait_rd();
            d = bus.rd_data; a = bus.mem_address; stable = 1'b1;
            repeat (5) begin
                tick();
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== d || bus.mem_address !== a) stable = 1'b0;
            end
            total++; if (!stable || d !== ed[i] || a !== ea[i]) begin
                bad++; $display("FAIL bp_beat%0d: stable=%0d data=%h addr=%0d want 1 %h %0d", i, stable, d, a, ed[i], ea[i]); end
            bus.rd_ready = 1'b1;
            tick();
            bus.rd_ready = 1'b0;
        end
        wait_idle();
    endtask

    task automatic test_wr_gaps();
        int v0 = viol;
        strobe_q.delete();
        send_cmd(1'b1, 5'd10, 5'd4);
        for (int i = 0; i < 5; i++) write_beat(16'h1111 * (i + 1), i);
        wait_idle();
        tick();
        total++; if (viol != v0) begin bad++; $display("FAIL gap_protocol: violations=%0d want 0", viol - v0); end
        total++; if (strobe_q.size() != 5) begin bad++; $display("FAIL gap_strobes: got %0d want 5", strobe_q.size()); end
        else for (int i = 0; i < 5; i++) begin
            total++; if (strobe_q[i] !== 5'(10 + i) || mem_arr[10 + i] !== 16'(16'h1111 * (i + 1))) begin
                bad++; $display("FAIL gap_beat%0d: addr=%0d data=%h want %0d %h", i, strobe_q[i], mem_arr[10 + i], 10 + i, 16'h1111 * (i + 1)); end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        strobe_q.delete();
        send_cmd(1'b1, 5'd20, 5'd3);
        write_beat(16'h1234, 0);
        bus.wr_data = 16'h5678; bus.wr_valid = 1'b1;
        while (bus.wr_ready !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        bus.wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            bad++; $display("FAIL rst_mid: we=%b busy=%b wr_ready=%b cmd_ready=%b want 0000", bus.mem_we, bus.busy, bus.wr_ready, bus.cmd_ready); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        total++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_idle: cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy); end
        total++; if (strobe_q.size() != 1 || mem_arr[20] !== 16'h1234) begin
            bad++; $display("FAIL rst_mid_mem: strobes=%0d mem[20]=%h want 1 1234", strobe_q.size(), mem_arr[20]); end
    endtask

    task automatic test_reset_strobe();
        send_cmd(1'b1, 5'd25, 5'd0);
        write_beat(16'hBEEF, 0);
        tick();
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL rst_strobe_pre: we=%b want 1", bus.mem_we); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_strobe_async: we=%b want 0", bus.mem_we); end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

`ifdef MEM_BURST_MASTER_CHECKSUM_EN
    task automatic test_checksum();
        int n = 0;
        send_cmd(1'b1, 5'd5, 5'd1);
        total++; if (bus.checksum !== 16'h0) begin bad++; $display("FAIL csum_clear: got %h want 0000", bus.checksum); end
        write_beat(16'h00FF, 0);
        write_beat(16'h0F0F, 0);
        while (bus.done !== 1'b1 && n < 50) begin tick(); n++; end
        total++; if (bus.done !== 1'b1 || bus.checksum !== 16'h0FF0) begin
            bad++; $display("FAIL csum_done: done=%b checksum=%h want 1 0ff0", bus.done, bus.checksum); end
        wait_idle();
        tick();
        total++; if (bus.checksum !== 16'h0FF0) begin bad++; $display("FAIL csum_hold: got %h want 0ff0", bus.checksum); end
    endtask
`endif

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_rd_backpressure();
        test_wr_gaps();
`ifdef MEM_BURST_MASTER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_burst();
        test_reset_strobe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
